conv_window_fetch: RTL and testbench

CONV_WINDOW_FETCH -- requirements
Module: conv_window_fetch

---
 rtl/conv_window_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_conv_window_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks an IMG_W x IMG_H image held in a read-only SRAM and
// delivers every interior 3x3 window (no padding) in raster order, valid/ready.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 one-cycle scan request, honoured only while idle
//   busy, done            scan in progress / one-cycle end-of-scan pulse
//   sram_en, sram_wen     read strobe / write enable (active low, tied off)
//   sram_addr, sram_d     read address / write data (tied to zero)
//   sram_q                read data, valid the cycle after the address
//   win_valid, win_ready  window handshake
//   win_data              tap k = 3*dy+dx at bits [8k+7:8k]
//   win_row, win_col      centre coordinates of the presented window
module conv_window_fetch #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sram_en,
    output logic        sram_wen,
    output logic [14:0] sram_addr,
    output logic [7:0]  sram_d,
    input  logic [7:0]  sram_q,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win_data,
    output logic [6:0]  win_row,
    output logic [7:0]  win_col
);

    localparam int         LW     = $clog2(IMG_W);
    localparam logic [6:0] R_LAST = 7'(IMG_H - 2);
    localparam logic [7:0] C_LAST = 8'(IMG_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LAST,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]  k;
    logic [6:0]  r;
    logic [7:0]  c;
    logic [1:0]  dy;
    logic [1:0]  dx;
    logic [14:0] row_i;
    logic [14:0] col_i;
    logic [14:0] rd_addr;
    logic [6:0]  cap_pos;
    logic        accept;
    logic        last_win;

    assign accept   = (state == OUT) && win_ready;
    assign last_win = (r == R_LAST) && (c == C_LAST);

    assign sram_wen = 1'b1;
    assign sram_d   = 8'd0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (k == 4'd8) begin
                    state_nx = LAST;
                end
            end
            LAST: begin
                state_nx = OUT;
            end
            OUT: begin
                if (win_ready) begin
                    state_nx = last_win ? IDLE : ISSUE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Tap offset within the 3x3 neighbourhood for read k
    always_comb begin
        dy = 2'd0;
        dx = 2'd0;
        unique case (k)
            4'd0: begin dy = 2'd0; dx = 2'd0; end
            4'd1: begin dy = 2'd0; dx = 2'd1; end
            4'd2: begin dy = 2'd0; dx = 2'd2; end
            4'd3: begin dy = 2'd1; dx = 2'd0; end
            4'd4: begin dy = 2'd1; dx = 2'd1; end
            4'd5: begin dy = 2'd1; dx = 2'd2; end
            4'd6: begin dy = 2'd2; dx = 2'd0; end
            4'd7: begin dy = 2'd2; dx = 2'd1; end
            4'd8: begin dy = 2'd2; dx = 2'd2; end
            default: begin dy = 2'd0; dx = 2'd0; end
        endcase
    end

    // Centre is never on the border, so r-1+dy and c-1+dx never underflow
    // and the column never crosses into the neighbouring row.
    assign row_i   = 15'(r) + 15'(dy) - 15'd1;
    assign col_i   = 15'(c) + 15'(dx) - 15'd1;
    assign rd_addr = (row_i << LW) + col_i;

    // Read k's data arrives while k+1 is being issued, so capture lags by one.
    assign cap_pos = {k - 4'd1, 3'b000};

    // Output logic
    always_comb begin
        busy      = 1'b0;
        sram_en   = 1'b0;
        sram_addr = 15'd0;
        win_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            ISSUE: begin
                busy      = 1'b1;
                sram_en   = 1'b1;
                sram_addr = rd_addr;
            end
            LAST: begin
                busy = 1'b1;
            end
            OUT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: read index, window position, tap capture
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= 4'd0;
            r        <= 7'd1;
            c        <= 8'd1;
            win_data <= 72'd0;
            win_row  <= 7'd0;
            win_col  <= 8'd0;
            done     <= 1'b0;
        end else begin
            done <= accept && last_win;

            if (state == ISSUE) begin
                k <= k + 4'd1;
                if (k != 4'd0) begin
                    win_data[cap_pos +: 8] <= sram_q;
                end
            end else begin
                k <= 4'd0;
            end

            if (state == LAST) begin
                win_data[71:64] <= sram_q;
                win_row         <= r;
                win_col         <= c;
            end

            if (accept) begin
                if (last_win) begin
                    r <= 7'd1;
                    c <= 8'd1;
                end else if (c == C_LAST) begin
                    r <= r + 7'd1;
                    c <= 8'd1;
                end else begin
                    c <= c + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: a timing/position model of the scan is checked
// against the DUT every cycle while win_ready is driven in several patterns.
module tb_conv_window_fetch;

    localparam int TW   = 16;
    localparam int TH   = 8;
    localparam int NWIN = (TW - 2) * (TH - 2);

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        sram_en;
    logic        sram_wen;
    logic [14:0] sram_addr;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [6:0]  win_row;
    logic [7:0]  win_col;

    logic [7:0] mem [0:32767];

    int n_tests;
    int n_fail;
    int rmode;

    // model state, owned by the monitor
    int m_busy;
    int m_done;
    int m_ph;
    int m_r;
    int m_c;
    int m_wins;
    int dut_dones;
    int post_rst;
    int prev_stall;
    logic [71:0] prev_data;

    conv_window_fetch #(
        .IMG_W(TW),
        .IMG_H(TH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sram_en  (sram_en),
        .sram_wen (sram_wen),
        .sram_addr(sram_addr),
        .sram_d   (sram_d),
        .sram_q   (sram_q),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data (win_data),
        .win_row  (win_row),
        .win_col  (win_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            sram_q <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(int r, int c, int k);
        return (r - 1 + k / 3) * TW + (c - 1 + k % 3);
    endfunction

    function automatic logic [71:0] exp_win(int r, int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = mem[exp_addr(r, c, k)];
        end
        return w;
    endfunction

    initial begin
        m_busy = 0; m_done = 0; m_ph = 0; m_r = 1; m_c = 1;
        m_wins = 0; dut_dones = 0; post_rst = 0; prev_stall = 0;
        prev_data = '0;
    end

    // Monitor: compare, then advance the model on the inputs of this cycle.
    always @(negedge clk) begin
        chk("wen", 72'(sram_wen), 72'd1);
        chk("sram_d", 72'(sram_d), 72'd0);
        if (post_rst != 0) begin
            chk("rst_en", 72'(sram_en), 72'd0);
            chk("rst_addr", 72'(sram_addr), 72'd0);
            chk("rst_valid", 72'(win_valid), 72'd0);
            chk("rst_data", win_data, 72'd0);
            chk("rst_row", 72'(win_row), 72'd0);
            chk("rst_col", 72'(win_col), 72'd0);
        end
        chk("busy", 72'(busy), 72'(m_busy != 0));
        chk("done", 72'(done), 72'(m_done != 0));
        chk("en", 72'(sram_en), 72'(m_busy != 0 && m_ph < 9));
        chk("valid", 72'(win_valid), 72'(m_busy != 0 && m_ph >= 10));
        if (m_busy != 0 && m_ph < 9 && sram_en) begin
            chk("addr", 72'(sram_addr), 72'(exp_addr(m_r, m_c, m_ph)));
        end
        if (m_busy != 0 && m_ph >= 10 && win_valid) begin
            chk("data", win_data, exp_win(m_r, m_c));
            chk("row", 72'(win_row), 72'(m_r));
            chk("col", 72'(win_col), 72'(m_c));
        end
        if (prev_stall != 0) begin
            chk("hold", win_data, prev_data);
        end
        if (done) dut_dones++;
        prev_stall = (win_valid && !win_ready && !rst) ? 1 : 0;
        prev_data  = win_data;

        m_done = 0;
        if (rst) begin
            m_busy = 0; m_ph = 0; m_r = 1; m_c = 1;
            post_rst = 1;
        end else begin
            post_rst = 0;
            if (m_busy != 0) begin
                if (m_ph < 10) begin
                    m_ph++;
                end else if (win_ready) begin
                    m_wins++;
                    m_ph = 0;
                    if (m_r == TH - 2 && m_c == TW - 2) begin
                        m_busy = 0; m_done = 1; m_r = 1; m_c = 1;
                    end else if (m_c == TW - 2) begin
                        m_c = 1; m_r++;
                    end else begin
                        m_c++;
                    end
                end
            end else if (start) begin
                m_busy = 1; m_ph = 0; m_r = 1; m_c = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        case (rmode)
            0: win_ready = 1'b0;
            1: win_ready = 1'b1;
            default: win_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit hit;
        d0  = dut_dones;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (dut_dones != d0) hit = 1;
        end
        chk("done_seen", 72'(hit), 72'd1);
        tick();
    endtask

    initial begin
        int base;
        int d0;
        bit hit;
        n_tests = 0;
        n_fail  = 0;
        rmode   = 1;
        rst     = 1'b1;
        start   = 1'b0;
        win_ready = 1'b0;
        for (int a = 0; a < 32768; a++) begin
            mem[a] = 8'($urandom);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // full scan, consumer always ready
        rmode = 1;
        base  = m_wins;
        d0    = dut_dones;
        pulse_start();
        wait_done(NWIN * 11 + 20);
        chk("wins_full", 72'(m_wins - base), 72'(NWIN));
        chk("dones_full", 72'(dut_dones - d0), 72'd1);

        // long back-pressure on the first window, then random ready
        rmode = 0;
        base  = m_wins;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (win_valid) hit = 1;
            else tick();
        end
        chk("first_valid", 72'(hit), 72'd1);
        repeat (20) tick();
        rmode = 2;
        wait_done(NWIN * 40);
        chk("wins_stall", 72'(m_wins - base), 72'(NWIN));

        // start pulses while busy must not disturb the scan
        rmode = 2;
        base  = m_wins;
        d0    = dut_dones;
        pulse_start();
        repeat (30) tick();
        pulse_start();
        repeat (57) tick();
        pulse_start();
        wait_done(NWIN * 40);
        chk("wins_restart", 72'(m_wins - base), 72'(NWIN));
        chk("dones_restart", 72'(dut_dones - d0), 72'd1);

        // reset while reading window 3, then a fresh scan
        rmode = 1;
        base  = m_wins;
        d0    = dut_dones;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_wins - base >= 2) hit = 1;
            else tick();
        end
        chk("reach_w3", 72'(hit), 72'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("abort_nodone", 72'(dut_dones - d0), 72'd0);
        chk("abort_idle", 72'(busy), 72'd0);
        base = m_wins;
        pulse_start();
        wait_done(NWIN * 11 + 20);
        chk("wins_after_rst", 72'(m_wins - base), 72'(NWIN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
